// File: rtl/dbg_uart_bridge.sv
// Byte-command bridge from the debug UART to the 16-bit system bus.
// Decodes address/data loads, bus reads/writes, status and bus-ownership commands.
module dbg_uart_bridge (
    input  logic        clk,
    input  logic        reset,
    input  logic        dix,
    output logic        dox,
    input  logic [7:0]  id,
    output logic [7:0]  od,
    output logic        csu,
    output logic [15:0] addru,
    output logic        ru,
    output logic [1:0]  wru,
    input  logic [15:0] data,
    output logic [15:0] datau,
    input  logic [7:0]  status
);

    typedef enum logic [2:0] {IDLE, ARG1, ARG2, WR, RD1, RD2, SEND} state_t;

    state_t      state, state_next;
    logic        arg_data;   // 1: argument pair loads datau, 0: loads addru
    logic [7:0]  arg_hi;
    logic [1:0]  wr_sel;
    logic [15:0] rd_lat;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        ru         = 1'b0;
        wru        = 2'b00;
        dox        = 1'b0;
        case (state)
            IDLE: begin
                if (dix) begin
                    case (id)
                        8'h10, 8'h11:        state_next = ARG1;
                        8'h21, 8'h22, 8'h23: state_next = WR;
                        8'h30:               state_next = RD1;
                        8'h31, 8'h32:        state_next = SEND;
                        default:             state_next = IDLE;
                    endcase
                end
            end
            ARG1: if (dix) state_next = ARG2;
            ARG2: if (dix) state_next = IDLE;
            WR: begin
                wru        = wr_sel;
                state_next = IDLE;
            end
            RD1: begin
                ru         = 1'b1;
                state_next = RD2;
            end
            RD2: begin
                ru         = 1'b1;
                state_next = SEND;
            end
            SEND: begin
                dox        = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            csu      <= 1'b0;
            addru    <= 16'h0000;
            datau    <= 16'h0000;
            od       <= 8'h00;
            rd_lat   <= 16'h0000;
            arg_data <= 1'b0;
            arg_hi   <= 8'h00;
            wr_sel   <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (dix) begin
                        case (id)
                            8'h10:               arg_data <= 1'b0;
                            8'h11:               arg_data <= 1'b1;
                            // 0x21 -> 10, 0x22 -> 01, 0x23 -> 11
                            8'h21, 8'h22, 8'h23: wr_sel <= {id[0], id[1]};
                            8'h31:               od <= rd_lat[7:0];
                            8'h32:               od <= status;
                            8'h40:               csu <= 1'b1;
                            8'h41:               csu <= 1'b0;
                            default: ;
                        endcase
                    end
                end
                ARG1: if (dix) arg_hi <= id;
                ARG2: begin
                    if (dix) begin
                        if (arg_data) datau <= {arg_hi, id};
                        else          addru <= {arg_hi, id};
                    end
                end
                WR: if (wr_sel == 2'b11) addru <= addru + 16'd2;
                RD2: begin
                    rd_lat <= data;
                    od     <= data[15:8];
                    addru  <= addru + 16'd2;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dbg_uart_bridge.sv
// Self-checking bench: command-level model drives per-cycle expectations,
// one negedge process compares every output every cycle.
module tb_dbg_uart_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic        dix;
    logic        dox;
    logic [7:0]  id;
    logic [7:0]  od;
    logic        csu;
    logic [15:0] addru;
    logic        ru;
    logic [1:0]  wru;
    logic [15:0] data;
    logic [15:0] datau;
    logic [7:0]  status;

    dbg_uart_bridge dut (
        .clk(clk), .reset(reset), .dix(dix), .dox(dox), .id(id), .od(od),
        .csu(csu), .addru(addru), .ru(ru), .wru(wru), .data(data),
        .datau(datau), .status(status)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic run = 1'b1;

    // Model expectations for the current cycle
    logic        e_csu, e_ru, e_dox;
    logic [1:0]  e_wru;
    logic [15:0] e_addru, e_datau, m_lat;
    logic [7:0]  e_od;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (run) begin
            chk("csu",   {15'd0, csu}, {15'd0, e_csu});
            chk("addru", addru, e_addru);
            chk("datau", datau, e_datau);
            chk("ru",    {15'd0, ru}, {15'd0, e_ru});
            chk("wru",   {14'd0, wru}, {14'd0, e_wru});
            chk("dox",   {15'd0, dox}, {15'd0, e_dox});
            chk("od",    {8'd0, od}, {8'd0, e_od});
        end
    end

    task automatic model_reset();
        e_csu = 0; e_ru = 0; e_dox = 0; e_wru = 2'b00;
        e_addru = 16'h0; e_datau = 16'h0; e_od = 8'h0; m_lat = 16'h0;
    endtask

    // Advance one cycle; pulse outputs default to idle
    task automatic step();
        @(posedge clk); #1;
        e_ru = 0; e_wru = 2'b00; e_dox = 0;
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Present one byte for one cycle; returns in the following cycle
    task automatic send_byte(input logic [7:0] b);
        step();
        id = b; dix = 1'b1;
        step();
        dix = 1'b0; id = $urandom_range(0, 255);
    endtask

    task automatic pulse_reset();
        step();
        reset = 1'b1; dix = 1'b0;
        model_reset();
        step();
        reset = 1'b0;
    endtask

    task automatic do_cmd(input logic [7:0] op, input logic [7:0] a1, input logic [7:0] a2);
        send_byte(op);
        case (op)
            8'h10, 8'h11: begin
                gap($urandom_range(0, 2));
                send_byte(a1);
                gap($urandom_range(0, 2));
                send_byte(a2);
                if (op == 8'h10) e_addru = {a1, a2};
                else             e_datau = {a1, a2};
            end
            8'h21, 8'h22, 8'h23: begin
                e_wru = (op == 8'h21) ? 2'b10 : (op == 8'h22) ? 2'b01 : 2'b11;
                step();
                if (op == 8'h23) e_addru = e_addru + 16'd2;
            end
            8'h30: begin
                e_ru = 1;
                step();
                e_ru = 1;
                step();
                m_lat = data;
                e_dox = 1; e_od = data[15:8];
                e_addru = e_addru + 16'd2;
                step();
            end
            8'h31: begin
                e_dox = 1; e_od = m_lat[7:0];
                step();
            end
            8'h32: begin
                e_dox = 1; e_od = status;
                step();
            end
            8'h40: e_csu = 1;
            8'h41: e_csu = 0;
            default: ;
        endcase
        gap($urandom_range(0, 2));
    endtask

    logic [7:0] ops [0:14] = '{8'h10, 8'h11, 8'h21, 8'h22, 8'h23, 8'h30, 8'h31,
                               8'h32, 8'h40, 8'h41, 8'h00, 8'h55, 8'hFF, 8'h12, 8'h33};

    initial begin
        reset = 1'b1; dix = 1'b0; id = 8'h00; data = 16'h0; status = 8'h0;
        model_reset();
        gap(2);
        reset = 1'b0;
        gap(1);

        do_cmd(8'h40, 0, 0);
        chk("lit_csu_acq", {15'd0, csu}, 16'd1);
        do_cmd(8'h41, 0, 0);
        chk("lit_csu_rel", {15'd0, csu}, 16'd0);

        do_cmd(8'h10, 8'h12, 8'h34);
        do_cmd(8'h11, 8'hAB, 8'hCD);
        chk("lit_addr_set", addru, 16'h1234);
        chk("lit_data_set", datau, 16'hABCD);
        do_cmd(8'h23, 0, 0);
        chk("lit_addr_inc", addru, 16'h1236);

        data = 16'hBEEF;
        do_cmd(8'h10, 8'h20, 8'h00);
        do_cmd(8'h30, 0, 0);
        chk("lit_read_hi", {8'd0, od}, 16'h00BE);
        chk("lit_read_addr", addru, 16'h2002);
        data = 16'h1111;
        do_cmd(8'h31, 0, 0);
        chk("lit_read_lo", {8'd0, od}, 16'h00EF);

        do_cmd(8'h21, 0, 0);
        chk("lit_wr_hi_addr", addru, 16'h2002);
        do_cmd(8'h22, 0, 0);
        chk("lit_wr_lo_addr", addru, 16'h2002);

        status = 8'h29;
        do_cmd(8'h32, 0, 0);
        chk("lit_status", {8'd0, od}, 16'h0029);

        do_cmd(8'h10, 8'hFF, 8'hFE);
        do_cmd(8'h23, 0, 0);
        chk("lit_addr_wrap", addru, 16'h0000);

        do_cmd(8'h10, 8'h12, 8'h34);
        send_byte(8'h10);
        send_byte(8'h55);
        pulse_reset();
        chk("lit_reset_addr", addru, 16'h0000);
        send_byte(8'h55);
        gap(3);
        chk("lit_ignored_addr", addru, 16'h0000);
        chk("lit_ignored_od", {8'd0, od}, 16'h0000);

        for (int n = 0; n < 300; n++) begin
            data   = $urandom_range(0, 65535);
            status = $urandom_range(0, 255);
            if ($urandom_range(0, 49) == 0) pulse_reset();
            do_cmd(ops[$urandom_range(0, 14)], $urandom_range(0, 255), $urandom_range(0, 255));
        end

        gap(2);
        @(posedge clk); #1;
        run = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
